uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter, partner to the UART receiver: 8 data bits, LSB first,
//  1 start bit (0), 1 stop bit (1), no parity; line idles high.
//  Has a small byte FIFO with valid/ready input so a host can queue bursts.
//  Sits between host logic and the serial TX pin, in the same clock domain.
// PARAMETERS
//  CLKS_PER_BIT  104  clocks per UART bit = f(ip_Clock)/baud (12M/115200); >=2
//  FIFO_DEPTH    4    byte FIFO entries; power of 2, >=2
// PORTS
//  ip_Clock      in   1  system clock, rising edge
//  ip_Reset      in   1  asynchronous, active-high reset
//  ip_Tx_DV      in   1  host byte valid
//  ip_Tx_Byte    in   8  host byte, sampled when ip_Tx_DV && op_Tx_Ready
//  op_Tx_Ready   out  1  FIFO can accept a byte (count < FIFO_DEPTH)
//  op_Tx_Serial  out  1  serial line, registered
//  op_Tx_Active  out  1  frame in progress (START..STOP)
//  op_Tx_Done    out  1  one-cycle pulse at end of each stop bit
// BEHAVIOUR
//  Reset (async, immediate): op_Tx_Serial=1, op_Tx_Active=0, op_Tx_Done=0,
//   op_Tx_Ready=1, FIFO empty, state IDLE, counters 0. Reset mid-frame aborts
//   the frame (line returns high at once) and discards all queued bytes.
//  FIFO: push when ip_Tx_DV && op_Tx_Ready; pop when IDLE and not empty.
//   Push+pop same edge: count unchanged, both happen. Full: push ignored, byte
//   lost, no error flag. Pointers wrap modulo FIFO_DEPTH; count is
//   $clog2(FIFO_DEPTH)+1 bits. op_Tx_Ready derived from registered count.
//  Bit counter: $clog2(CLKS_PER_BIT) bits; each bit held exactly CLKS_PER_BIT
//   clocks (counter 0..CLKS_PER_BIT-1).
//  FSM:
//   IDLE : serial=1, active=0. If FIFO non-empty: pop into shift reg,
//          serial<=0, active<=1, count<=0 -> START.
//   START: after CLKS_PER_BIT clocks: serial<=shift[0], bit_idx<=0 -> DATA.
//   DATA : every CLKS_PER_BIT clocks advance bit; after bit 7 serial<=1 -> STOP.
//   STOP : after CLKS_PER_BIT clocks: active<=0, done<=1 -> IDLE.
//   illegal state -> IDLE, serial=1.
//  op_Tx_Done high exactly the cycle after STOP completes (cycle spent in IDLE).
//  Latency: byte accepted at edge N into empty FIFO, idle FSM -> serial low
//   from edge N+1. Frame = 10*CLKS_PER_BIT clocks of START..STOP.
//  Back-to-back queued bytes: exactly one extra high cycle between the stop
//   bit end and the next start bit (stop effectively CLKS_PER_BIT+1 clocks).
//  ip_Tx_Byte changes after acceptance never affect the frame in flight.
// TESTING (use CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
//  1. Reset, push 0xA5 once -> serial low at N+1, then bits 1,0,1,0,0,1,0,1
//     each 4 clks, stop high 4 clks; Done pulses 1 clk; Active high 40 clks.
//  2. Push 0x00,0xFF,0x55 on 3 consecutive clocks -> three frames, each
//     separated by one idle-high clk; 3 Done pulses; RX model decodes bytes.
//  3. Hold ip_Tx_DV high with 6 distinct bytes while idle-busy -> Ready drops
//     when 4 queued (5th accepted only after first pop); rejected bytes absent.
//  4. Assert ip_Reset mid-DATA of 0x3C with 2 bytes queued -> serial=1,
//     Active=0 same cycle, Ready=1; after release line stays high, no frame.
//  5. Push while FIFO full and FSM popping same edge -> Ready=0 so no push;
//     count drops by 1; next cycle Ready=1 and push succeeds.
//  6. CLKS_PER_BIT=104 (default): push 0x81 -> each bit exactly 104 clks,
//     frame 1040 clks, Done 1 clk.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, idle-high line, with a small
// byte FIFO in front so the host can queue bursts with valid/ready.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte; pops the FIFO head when present
// START | start bit (line low) for CLKS_PER_BIT clocks
// DATA  | data bits 0..7, LSB first, each CLKS_PER_BIT clocks
// STOP  | stop bit (line high) for CLKS_PER_BIT clocks, then Done pulse
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       ip_Clock,
    input  logic       ip_Reset,
    input  logic       ip_Tx_DV,
    input  logic [7:0] ip_Tx_Byte,
    output logic       op_Tx_Ready,
    output logic       op_Tx_Serial,
    output logic       op_Tx_Active,
    output logic       op_Tx_Done
);

    localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             bit_end;

    // Ready comes straight from the registered count, so a full FIFO that is
    // popped this edge still refuses the byte offered on the same edge.
    assign op_Tx_Ready  = (count_q < FIFO_FULL);
    assign fifo_empty   = (count_q == '0);
    assign push         = ip_Tx_DV && op_Tx_Ready;
    assign pop          = (state_q == ST_IDLE) && !fifo_empty;
    assign bit_end      = (clk_cnt_q == CNT_LAST);

    assign op_Tx_Serial = serial_q;
    assign op_Tx_Active = active_q;
    assign op_Tx_Done   = done_q;

    // FIFO pointer and occupancy next-state; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + FIFO_CNT_W'(1);
            2'b01:   count_d = count_q - FIFO_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count; reset discards everything queued.
    always_ff @(posedge ip_Clock or posedge ip_Reset) begin
        if (ip_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge ip_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ip_Tx_Byte;
        end
    end

    // Frame sequencing: the byte is copied into the shift register on pop, so
    // later changes on ip_Tx_Byte or the FIFO cannot disturb the frame in flight.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    shift_d  = mem_q[rd_ptr_q];
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    serial_d  = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        serial_d = 1'b1;
                        state_d  = ST_STOP;
                    end else begin
                        // shift_q[0] is on the line now; the next bit is shift_q[1].
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[1];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    active_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // FSM and line registers; reset aborts any frame and returns the line high at once.
    always_ff @(posedge ip_Clock or posedge ip_Reset) begin
        if (ip_Reset) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 4 clocks/bit for framing, FIFO
// and reset behaviour, one at the default 104 clocks/bit for bit timing.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] tx_byte;
    logic       ready, serial, active, done;

    logic       dv6;
    logic [7:0] tx_byte6;
    logic       ready6, serial6, active6, done6;

    int n_asserts = 0;
    int n_fail    = 0;

    // line decoder state
    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         done_cnt  = 0;
    int         frame_err = 0;
    bit         in_frame  = 1'b0;
    int         samp      = 0;
    int         high_run  = 0;
    logic [7:0] rx_shift  = 8'h00;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .ip_Clock     (clk),
        .ip_Reset     (rst),
        .ip_Tx_DV     (dv),
        .ip_Tx_Byte   (tx_byte),
        .op_Tx_Ready  (ready),
        .op_Tx_Serial (serial),
        .op_Tx_Active (active),
        .op_Tx_Done   (done)
    );

    uart_tx dut104 (
        .ip_Clock     (clk),
        .ip_Reset     (rst),
        .ip_Tx_DV     (dv6),
        .ip_Tx_Byte   (tx_byte6),
        .op_Tx_Ready  (ready6),
        .op_Tx_Serial (serial6),
        .op_Tx_Active (active6),
        .op_Tx_Done   (done6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Walks one whole frame cycle by cycle, starting at the first start-bit sample.
    task automatic check_frame(input string tag, input logic [7:0] b, input int cpb, input bit big);
        logic exp_bit;
        int   errs;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      exp_bit = 1'b0;
            else if (k == 9) exp_bit = 1'b1;
            else             exp_bit = b[k-1];
            errs = 0;
            for (int c = 0; c < cpb; c++) begin
                if ((big ? serial6 : serial) !== exp_bit) errs++;
                if ((big ? active6 : active) !== 1'b1)    errs++;
                if ((big ? done6 : done) !== 1'b0)        errs++;
                tick();
            end
            check($sformatf("%s_bit%0d_errs", tag, k), 32'(errs), 32'd0);
        end
        check({tag, "_done_pulse"}, 32'(big ? done6 : done), 32'd1);
        check({tag, "_active_end"}, 32'(big ? active6 : active), 32'd0);
        check({tag, "_line_high"},  32'(big ? serial6 : serial), 32'd1);
    endtask

    // Independent 8N1 decoder on the 4-clk/bit line, sampling mid-bit.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_frame = 1'b0;
                high_run = 0;
                samp     = 0;
            end else if (!in_frame) begin
                if (serial === 1'b0) begin
                    in_frame = 1'b1;
                    samp     = 0;
                    rx_shift = 8'h00;
                    gap_q.push_back(high_run);
                    high_run = 0;
                end else begin
                    high_run++;
                end
            end else begin
                samp++;
                if (samp >= 6 && samp <= 34 && ((samp - 6) % 4) == 0)
                    rx_shift[3'((samp - 6) / 4)] = serial;
                if (samp >= 36) high_run++;
                if (samp == 38) begin
                    if (serial !== 1'b1) frame_err++;
                    rx_q.push_back(rx_shift);
                end
                if (samp == 39) in_frame = 1'b0;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        int rbase, gbase, dbase, bad;

        rst = 1'b1; dv = 1'b0; tx_byte = 8'h00; dv6 = 1'b0; tx_byte6 = 8'h00;
        repeat (3) tick();
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_serial104", 32'(serial6), 32'd1);
        rst = 1'b0;
        repeat (2) tick();

        // 1: single byte 0xA5, exact per-cycle framing
        dbase = done_cnt; rbase = rx_q.size();
        dv = 1'b1; tx_byte = 8'hA5;
        tick();
        check("t1_line_high_at_accept", 32'(serial), 32'd1);
        dv = 1'b0; tx_byte = 8'h5A;
        tick();
        check_frame("t1", 8'hA5, CPB, 1'b0);
        tick();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_done_count", 32'(done_cnt - dbase), 32'd1);
        check("t1_rx_byte", 32'(rx_q[rbase]), 32'hA5);

        // 2: three bytes on consecutive clocks, one idle-high clock between frames
        dbase = done_cnt; rbase = rx_q.size(); gbase = gap_q.size();
        dv = 1'b1; tx_byte = 8'h00;
        tick();
        check("t2_line_high_at_accept", 32'(serial), 32'd1);
        tx_byte = 8'hFF;
        tick();
        check("t2_start_low", 32'(serial), 32'd0);
        tx_byte = 8'h55;
        tick();
        dv = 1'b0;
        repeat (125) tick();
        check("t2_rx_count", 32'(rx_q.size() - rbase), 32'd3);
        check("t2_rx0", 32'(rx_q[rbase]),     32'h00);
        check("t2_rx1", 32'(rx_q[rbase + 1]), 32'hFF);
        check("t2_rx2", 32'(rx_q[rbase + 2]), 32'h55);
        check("t2_gap1", 32'(gap_q[gbase + 1]), 32'(CPB + 1));
        check("t2_gap2", 32'(gap_q[gbase + 2]), 32'(CPB + 1));
        check("t2_done_count", 32'(done_cnt - dbase), 32'd3);

        // 3 + 5: fill FIFO while busy, overflow bytes dropped, push refused on pop edge
        dbase = done_cnt; rbase = rx_q.size();
        dv = 1'b1; tx_byte = 8'hF0; tick();
        tx_byte = 8'hB0; tick();
        tx_byte = 8'hB1; tick();
        tx_byte = 8'hB2; tick();
        tx_byte = 8'hB3; tick();
        check("t3_ready_full", 32'(ready), 32'd0);
        tx_byte = 8'hB4; tick();
        tx_byte = 8'hB5; tick();
        dv = 1'b0;
        check("t3_ready_still_full", 32'(ready), 32'd0);
        repeat (35) tick();
        check("t5_ready_before_pop", 32'(ready), 32'd0);
        dv = 1'b1; tx_byte = 8'hB6;
        tick();
        check("t5_ready_after_pop", 32'(ready), 32'd1);
        tick();
        check("t5_ready_after_push", 32'(ready), 32'd0);
        dv = 1'b0;
        repeat (210) tick();
        check("t3_rx_count", 32'(rx_q.size() - rbase), 32'd6);
        check("t3_rx0", 32'(rx_q[rbase]),     32'hF0);
        check("t3_rx1", 32'(rx_q[rbase + 1]), 32'hB0);
        check("t3_rx2", 32'(rx_q[rbase + 2]), 32'hB1);
        check("t3_rx3", 32'(rx_q[rbase + 3]), 32'hB2);
        check("t3_rx4", 32'(rx_q[rbase + 4]), 32'hB3);
        check("t5_rx5", 32'(rx_q[rbase + 5]), 32'hB6);
        check("t3_done_count", 32'(done_cnt - dbase), 32'd6);
        check("t3_ready_drained", 32'(ready), 32'd1);

        // 4: reset in the middle of DATA with two bytes queued
        dv = 1'b1; tx_byte = 8'h3C; tick();
        tx_byte = 8'hD1; tick();
        tx_byte = 8'hD2; tick();
        dv = 1'b0;
        repeat (12) tick();
        check("t4_active_mid_frame", 32'(active), 32'd1);
        check("t4_ready_queued", 32'(ready), 32'd1);
        rbase = rx_q.size(); dbase = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("t4_rst_serial", 32'(serial), 32'd1);
        check("t4_rst_active", 32'(active), 32'd0);
        check("t4_rst_ready",  32'(ready),  32'd1);
        check("t4_rst_done",   32'(done),   32'd0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (serial !== 1'b1 || active !== 1'b0) bad++;
        end
        check("t4_line_quiet_after_reset", 32'(bad), 32'd0);
        check("t4_no_frames", 32'(rx_q.size() - rbase), 32'd0);
        check("t4_no_done", 32'(done_cnt - dbase), 32'd0);
        check("frame_errors", 32'(frame_err), 32'd0);

        // 6: default 104 clocks per bit, byte 0x81
        dv6 = 1'b1; tx_byte6 = 8'h81;
        tick();
        check("t6_line_high_at_accept", 32'(serial6), 32'd1);
        dv6 = 1'b0; tx_byte6 = 8'h00;
        tick();
        check_frame("t6", 8'h81, 104, 1'b1);
        tick();
        check("t6_done_one_cycle", 32'(done6), 32'd0);
        check("t6_ready", 32'(ready6), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
